// File: rtl/axi_flat_pkg.sv
// Field layout of the flat AXI read request/response buses used by the SOC wrappers.
// Response offsets are relative to DATA_W, so one set of constants covers every data width.
package axi_flat_pkg;

  localparam int REQ_W      = 80;
  localparam int ADDR_LSB   = 0;
  localparam int ADDR_W     = 32;
  localparam int LEN_LSB    = 32;
  localparam int SIZE_LSB   = 40;
  localparam int BURST_LSB  = 43;
  localparam int ID_LSB     = 45;
  localparam int ID_W       = 12;
  localparam int PROT_LSB   = 57;
  localparam int CACHE_LSB  = 60;
  localparam int LOCK_BIT   = 64;
  localparam int REGION_LSB = 65;
  localparam int USER_LSB   = 69;
  localparam int QOS_LSB    = 75;
  localparam int VALID_BIT  = 79;

  localparam int RSP_LAST_OFS  = 0;
  localparam int RSP_RESP_OFS  = 1;
  localparam int RSP_ID_OFS    = 3;
  localparam int RSP_USER_OFS  = 15;
  localparam int RSP_VALID_OFS = 21;

  function automatic int rsp_w(input int data_w);
    return data_w + 22;
  endfunction

endpackage

// File: rtl/axi_rd_track_fifo.sv
// Outstanding-burst tracker: holds {client, original id} per accepted AR in issue order.
// The head is read combinationally so the R path can steer with no added latency.
module axi_rd_track_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is allowed then.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_read_mux.sv
// N:1 AXI read-channel mux: round-robin AR arbitration into a registered AR stage,
// single downstream ARID, and in-order R steering from the tracking FIFO head.
module axi_read_mux
  import axi_flat_pkg::*;
#(
  parameter int          N_PORTS  = 2,
  parameter int          DATA_W   = 64,
  parameter int          DEPTH    = 8,
  parameter logic [11:0] FIXED_ID = 12'h000
) (
  input  logic                           IP_CLK,
  input  logic                           IP_ARESET_N,
  input  logic [N_PORTS-1:0][REQ_W-1:0]  up_read_input,
  output logic [N_PORTS-1:0]             up_read_ready,
  output logic [N_PORTS-1:0][DATA_W+21:0] up_read_output,
  input  logic [N_PORTS-1:0]             up_read_ready_downstream,
  output logic [REQ_W-1:0]               dn_read_input,
  input  logic                           dn_read_ready,
  input  logic [DATA_W+21:0]             dn_read_output,
  output logic                           dn_read_ready_downstream
);

  localparam int RSP_W = rsp_w(DATA_W);
  localparam int P_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int TRK_W = P_W + ID_W;

  logic [N_PORTS-1:0] up_valid;
  logic [P_W-1:0]     rr_q, rr_d, grant;
  logic [P_W:0]       idx;
  logic               any_valid, accept, pop;
  logic               fifo_full, fifo_empty;
  logic [TRK_W-1:0]   trk_din, head;
  logic [P_W-1:0]     head_port;
  logic [ID_W-1:0]    head_id;
  logic [REQ_W-1:0]   ar_q, ar_d;
  logic               dn_beat_valid, dn_beat_last;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign up_valid[gi]      = up_read_input[gi][VALID_BIT];
    assign up_read_ready[gi] = accept && (grant == P_W'(gi));
  end

  // Scan downward so the lowest offset from rr (the first eligible client) wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (P_W+1)'(k);
      if (idx >= (P_W+1)'(N_PORTS)) idx = idx - (P_W+1)'(N_PORTS);
      if (up_valid[idx[P_W-1:0]]) begin
        grant     = idx[P_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  // Reset gates accept so ready stays low while held in reset.
  assign accept = IP_ARESET_N & any_valid & (~ar_q[VALID_BIT] | dn_read_ready)
                & (~fifo_full | pop);

  always_comb begin
    rr_d = rr_q;
    ar_d = ar_q;
    if (accept) begin
      rr_d = (grant == P_W'(N_PORTS - 1)) ? '0 : grant + P_W'(1);
      ar_d = up_read_input[grant];
      ar_d[ID_LSB +: ID_W] = FIXED_ID;
    end else if (dn_read_ready) begin
      ar_d = '0;
    end
  end

  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) begin
      rr_q <= '0;
      ar_q <= '0;
    end else begin
      rr_q <= rr_d;
      ar_q <= ar_d;
    end
  end

  assign dn_read_input = ar_q;
  assign trk_din       = {grant, up_read_input[grant][ID_LSB +: ID_W]};

  axi_rd_track_fifo #(
    .WIDTH (TRK_W),
    .DEPTH (DEPTH)
  ) u_track (
    .clk_i  (IP_CLK),
    .rst_ni (IP_ARESET_N),
    .push_i (accept),
    .din_i  (trk_din),
    .pop_i  (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

  assign head_port     = head[TRK_W-1 -: P_W];
  assign head_id       = head[ID_W-1:0];
  assign dn_beat_valid = dn_read_output[DATA_W + RSP_VALID_OFS];
  assign dn_beat_last  = dn_read_output[DATA_W + RSP_LAST_OFS];

  assign dn_read_ready_downstream = ~fifo_empty & up_read_ready_downstream[head_port];
  assign pop = dn_beat_valid & dn_beat_last & dn_read_ready_downstream;

  always_comb begin
    up_read_output = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!fifo_empty && head_port == P_W'(i)) begin
        up_read_output[i] = dn_read_output[RSP_W-1:0];
        up_read_output[i][DATA_W + RSP_ID_OFS +: ID_W] = head_id;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_mux.sv
// Directed bench for axi_read_mux: reset, round-robin, AR backpressure, R steering,
// client R stall and tracking-FIFO full with simultaneous pop/push.
module tb_axi_read_mux;

  localparam int          N     = 2;
  localparam int          DW    = 64;
  localparam int          DEPTH = 8;
  localparam int          RW    = DW + 22;
  localparam logic [11:0] FID   = 12'h7E5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0][79:0]    up_in;
  logic [N-1:0]          up_rdy;
  logic [N-1:0][RW-1:0]  up_out;
  logic [N-1:0]          up_rrdy;
  logic [79:0]           dn_in;
  logic                  dn_rdy;
  logic [RW-1:0]         dn_out;
  logic                  dn_rrdy;

  int n_vec    = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  axi_read_mux #(
    .N_PORTS  (N),
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .FIXED_ID (FID)
  ) dut (
    .IP_CLK                   (clk),
    .IP_ARESET_N              (rst_n),
    .up_read_input            (up_in),
    .up_read_ready            (up_rdy),
    .up_read_output           (up_out),
    .up_read_ready_downstream (up_rrdy),
    .dn_read_input            (dn_in),
    .dn_read_ready            (dn_rdy),
    .dn_read_output           (dn_out),
    .dn_read_ready_downstream (dn_rrdy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] mk_req(input logic [31:0] addr, input logic [7:0] len,
                                         input logic [11:0] id);
    logic [79:0] r;
    r        = '0;
    r[31:0]  = addr;
    r[39:32] = len;
    r[42:40] = 3'd3;
    r[44:43] = 2'b01;
    r[56:45] = id;
    r[59:57] = 3'b010;
    r[63:60] = 4'h3;
    r[68:65] = 4'h0;
    r[74:69] = 6'h2A;
    r[78:75] = 4'h5;
    r[79]    = 1'b1;
    return r;
  endfunction

  function automatic logic [RW-1:0] mk_beat(input logic [63:0] data, input logic last,
                                            input logic [11:0] id);
    logic [RW-1:0] b;
    b        = '0;
    b[63:0]  = data;
    b[64]    = last;
    b[66:65] = 2'b00;
    b[78:67] = id;
    b[84:79] = 6'h15;
    b[85]    = 1'b1;
    return b;
  endfunction

  initial begin
    logic        last;
    int          p;
    logic [11:0] eid;

    // Reset held with junk on every input.
    rst_n     = 1'b0;
    up_in[0]  = 80'({$urandom(), $urandom(), $urandom()});
    up_in[1]  = 80'({$urandom(), $urandom(), $urandom()});
    up_in[0][79] = 1'b1;
    up_in[1][79] = 1'b1;
    dn_rdy    = 1'b1;
    dn_out    = RW'({$urandom(), $urandom(), $urandom()});
    dn_out[RW-1] = 1'b1;
    dn_out[DW]   = 1'b1;
    up_rrdy   = 2'b11;
    repeat (3) step();
    #2;
    check("rst_up_ready", 128'(up_rdy), 128'(0));
    check("rst_dn_req", 128'(dn_in), 128'(0));
    check("rst_up_rsp0", 128'(up_out[0]), 128'(0));
    check("rst_up_rsp1", 128'(up_out[1]), 128'(0));
    check("rst_dn_rready", 128'(dn_rrdy), 128'(0));

    // Round robin: both clients valid, downstream always ready.
    step();
    rst_n    = 1'b1;
    up_in[0] = mk_req(32'h0000_1000, 8'd0, 12'h100);
    up_in[1] = mk_req(32'h0000_2000, 8'd0, 12'h201);
    dn_rdy   = 1'b1;
    dn_out   = '0;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("rr_grant", 128'(up_rdy), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      if (k > 0)
        check("rr_dn_req", 128'(dn_in), (k % 2 == 1) ? 128'(mk_req(32'h1000, 8'd0, FID))
                                                     : 128'(mk_req(32'h2000, 8'd0, FID)));
      step();
    end
    up_in[0][79] = 1'b0;
    up_in[1][79] = 1'b0;
    #2;
    check("rr_dn_req_last", 128'(dn_in), 128'(mk_req(32'h2000, 8'd0, FID)));
    check("idle_no_ready", 128'(up_rdy), 128'(0));
    step();
    #2;
    check("ar_clear", 128'(dn_in), 128'(0));

    // Drain the four single-beat bursts: p0,p1,p0,p1.
    for (int k = 0; k < 4; k++) begin
      dn_out = mk_beat(64'hA000 + 64'(k), 1'b1, FID);
      #2;
      p   = k % 2;
      eid = (p == 1) ? 12'h201 : 12'h100;
      check("drain_rsp", 128'(up_out[p]), 128'(mk_beat(64'hA000 + 64'(k), 1'b1, eid)));
      check("drain_other_valid", 128'(up_out[1-p][RW-1]), 128'(0));
      check("drain_rready", 128'(dn_rrdy), 128'(1));
      step();
    end
    #2;
    check("drain_empty_rready", 128'(dn_rrdy), 128'(0));
    check("drain_empty_rsp0", 128'(up_out[0]), 128'(0));
    dn_out = '0;

    // Backpressure: AR register loaded once, then held for 5 stalled cycles.
    step();
    dn_rdy   = 1'b0;
    up_in[0] = mk_req(32'h0000_3000, 8'd0, 12'h033);
    up_in[1] = mk_req(32'h0000_4000, 8'd0, 12'h044);
    #2;
    check("bp_first_accept", 128'(up_rdy), 128'(2'b01));
    step();
    repeat (5) begin
      #2;
      check("bp_hold_req", 128'(dn_in), 128'(mk_req(32'h3000, 8'd0, FID)));
      check("bp_no_ready", 128'(up_rdy), 128'(0));
      step();
    end
    up_in[0][79] = 1'b0;
    up_in[1][79] = 1'b0;
    dn_rdy = 1'b1;
    #2;
    check("bp_release_req", 128'(dn_in), 128'(mk_req(32'h3000, 8'd0, FID)));
    step();
    #2;
    check("bp_cleared", 128'(dn_in), 128'(0));
    dn_out = mk_beat(64'hB0, 1'b1, FID);
    #2;
    check("bp_rsp", 128'(up_out[0]), 128'(mk_beat(64'hB0, 1'b1, 12'h033)));
    step();
    dn_out = '0;

    // Steering: p1 len=3 id 0x5A, then p0 len=0 id 0x011.
    up_in[1] = mk_req(32'h0000_5000, 8'd3, 12'h05A);
    #2;
    check("st_grant_p1", 128'(up_rdy), 128'(2'b10));
    step();
    up_in[1][79] = 1'b0;
    up_in[0] = mk_req(32'h0000_6000, 8'd0, 12'h011);
    #2;
    check("st_grant_p0", 128'(up_rdy), 128'(2'b01));
    check("st_dn_req_p1", 128'(dn_in), 128'(mk_req(32'h5000, 8'd3, FID)));
    step();
    up_in[0][79] = 1'b0;
    for (int b = 0; b < 5; b++) begin
      last   = (b >= 3);
      p      = (b < 4) ? 1 : 0;
      eid    = (b < 4) ? 12'h05A : 12'h011;
      dn_out = mk_beat(64'hC0DE_0000 + 64'(b), last, FID);
      if (b == 3) begin
        // Client stalls on the last beat of the p1 burst.
        up_rrdy = 2'b01;
        #2;
        check("stall_rready", 128'(dn_rrdy), 128'(0));
        check("stall_rsp_held", 128'(up_out[1]), 128'(mk_beat(64'hC0DE_0003, 1'b1, 12'h05A)));
        step();
        up_rrdy = 2'b11;
      end
      #2;
      check("st_rsp", 128'(up_out[p]), 128'(mk_beat(64'hC0DE_0000 + 64'(b), last, eid)));
      check("st_other_valid", 128'(up_out[1-p][RW-1]), 128'(0));
      check("st_rready", 128'(dn_rrdy), 128'(1));
      step();
    end
    dn_out = '0;
    #2;
    check("st_empty_rready", 128'(dn_rrdy), 128'(0));

    // FIFO full: 8 accepts, 9th blocked until a last beat pops in the same cycle.
    up_in[0] = mk_req(32'h0000_7000, 8'd0, 12'h0A0);
    up_in[1] = mk_req(32'h0000_8000, 8'd0, 12'h0B1);
    for (int k = 0; k < 8; k++) begin
      #2;
      check("full_fill_grant", 128'(up_rdy), (k % 2 == 0) ? 128'(2'b10) : 128'(2'b01));
      step();
    end
    #2;
    check("full_no_ready", 128'(up_rdy), 128'(0));
    dn_out = mk_beat(64'hF0, 1'b1, FID);
    #1;
    check("full_pop_push_ready", 128'(up_rdy), 128'(2'b10));
    check("full_pop_rsp", 128'(up_out[1]), 128'(mk_beat(64'hF0, 1'b1, 12'h0B1)));
    step();
    up_in[0][79] = 1'b0;
    up_in[1][79] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      p      = (k % 2 == 0) ? 0 : 1;
      eid    = (p == 1) ? 12'h0B1 : 12'h0A0;
      dn_out = mk_beat(64'hE00 + 64'(k), 1'b1, FID);
      #2;
      check("full_drain_rsp", 128'(up_out[p]), 128'(mk_beat(64'hE00 + 64'(k), 1'b1, eid)));
      step();
    end
    #2;
    check("full_drained_rready", 128'(dn_rrdy), 128'(0));
    dn_out = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
